muldiv_hilo: RTL

//  Multi-cycle multiply/divide unit with HI/LO registers: executes the R_FORM

---
 rtl/muldiv_hilo.sv | 290 +++++++++++++++++++++++++++++
 1 files changed

// File: rtl/muldiv_hilo.sv
// ---------------------------------------------------------------------------
// muldiv_hilo
//   Multi-cycle multiply/divide unit owning the HI/LO register pair. Executes
//   MULT/MULTU/DIV/DIVU/MTHI/MTLO and supplies MFHI/MFLO read data. Sits
//   beside the ALU in EX and takes the decode-stage operands (rs -> A,
//   rt -> B).
//
//   Multiply: 32-step shift-add on operand magnitudes, sign fixed in FIX.
//   Divide:   32-step restoring divide on operand magnitudes, sign fixed in
//             FIX (quotient negated on sign mismatch, remainder follows A).
//   Divide by zero skips the iterations: Lo = all ones, Hi = A.
//
//   Optional feature macro: FAST_MULT_EN
//     defined   -> MULT/MULTU finish in the accept cycle (Busy stays low).
//     undefined -> MULT/MULTU use the iterative path (33-cycle latency).
//
// Ports
//   CLK     in   1     clock, posedge
//   RST     in   1     synchronous reset, active-low
//   Valid   in   1     Ins/A/B carry an issued instruction
//   Ins     in   32    instruction word (op = Ins[31:26], func = Ins[5:0])
//   A       in   XLEN  rs operand
//   B       in   XLEN  rt operand
//   Busy    out  1     long operation in flight
//   Stall   out  1     HI/LO-class op offered while Busy (issue must hold)
//   Done    out  1     one-cycle pulse after MULT*/DIV* update HI/LO
//   Hi      out  XLEN  HI register
//   Lo      out  XLEN  LO register
//   MfData  out  XLEN  Hi for MFHI, Lo otherwise
// ---------------------------------------------------------------------------
module muldiv_hilo #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 6
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            Valid,
    input  logic [31:0]     Ins,
    input  logic [XLEN-1:0] A,
    input  logic [XLEN-1:0] B,
    output logic            Busy,
    output logic            Stall,
    output logic            Done,
    output logic [XLEN-1:0] Hi,
    output logic [XLEN-1:0] Lo,
    output logic [XLEN-1:0] MfData
);

    localparam logic [5:0] R_FORM  = 6'h00;
    localparam logic [5:0] F_MFHI  = 6'h10;
    localparam logic [5:0] F_MTHI  = 6'h11;
    localparam logic [5:0] F_MFLO  = 6'h12;
    localparam logic [5:0] F_MTLO  = 6'h13;
    localparam logic [5:0] F_MULT  = 6'h18;
    localparam logic [5:0] F_MULTU = 6'h19;
    localparam logic [5:0] F_DIV   = 6'h1A;
    localparam logic [5:0] F_DIVU  = 6'h1B;

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL,
        S_DIV,
        S_FIX
    } state_t;

    state_t state, state_nx;

    logic [5:0]      op;
    logic [5:0]      func;
    logic            is_class;
    logic            accept;
    logic            start_mul;
    logic            start_div;
    logic            is_signed;
    logic            b_zero;
    logic            sign_diff;
    logic [XLEN-1:0] abs_a;
    logic [XLEN-1:0] abs_b;
    logic            ins_unused;

    // Working registers for the iterative datapath (not architectural).
    logic [XLEN-1:0] work_hi;
    logic [XLEN-1:0] work_lo;
    logic [XLEN-1:0] opnd;
    logic            neg_q;
    logic            neg_r;
    logic            mode_mul;
    logic [CNT_W-1:0] cnt;

    logic [XLEN:0]     mul_sum;
    logic [XLEN:0]     div_shift;
    logic              div_ge;
    logic [2*XLEN-1:0] fix_prod;
    logic [XLEN-1:0]   fix_hi;
    logic [XLEN-1:0]   fix_lo;

`ifdef FAST_MULT_EN
    logic [2*XLEN-1:0] fast_mag;
    logic [2*XLEN-1:0] fast_prod;
`endif

    function automatic logic [XLEN-1:0] abs_val(input logic [XLEN-1:0] x,
                                                input logic en);
        return (en && x[XLEN-1]) ? -x : x;
    endfunction

    function automatic logic [XLEN-1:0] neg_if(input logic [XLEN-1:0] x,
                                               input logic en);
        return en ? -x : x;
    endfunction

    // -----------------------------------------------------------------------
    // Decode
    // -----------------------------------------------------------------------
    assign op         = Ins[31:26];
    assign func       = Ins[5:0];
    assign ins_unused = ^Ins[25:6];

    always_comb begin
        is_class = 1'b0;
        if (op == R_FORM) begin
            case (func)
                F_MFHI, F_MTHI, F_MFLO, F_MTLO,
                F_MULT, F_MULTU, F_DIV, F_DIVU: is_class = 1'b1;
                default:                        is_class = 1'b0;
            endcase
        end
    end

    assign Busy      = (state != S_IDLE);
    assign Stall     = Valid && Busy && is_class;
    assign accept    = Valid && !Busy && is_class;
    assign start_mul = accept && (func == F_MULT || func == F_MULTU);
    assign start_div = accept && (func == F_DIV  || func == F_DIVU);
    assign is_signed = (func == F_MULT) || (func == F_DIV);
    assign b_zero    = (B == '0);
    assign sign_diff = is_signed && (A[XLEN-1] ^ B[XLEN-1]);
    assign abs_a     = abs_val(A, is_signed);
    assign abs_b     = abs_val(B, is_signed);

    assign MfData = (func == F_MFHI) ? Hi : Lo;

`ifdef FAST_MULT_EN
    assign fast_mag  = {{XLEN{1'b0}}, abs_a} * {{XLEN{1'b0}}, abs_b};
    assign fast_prod = sign_diff ? -fast_mag : fast_mag;
`endif

    // -----------------------------------------------------------------------
    // Iteration step logic
    // -----------------------------------------------------------------------
    // Shift-add: add multiplicand into the high half when the current
    // multiplier bit (LSB of work_lo) is set, then shift the pair right.
    assign mul_sum = {1'b0, work_hi} + {1'b0, (work_lo[0] ? opnd : '0)};

    // Restoring divide: 33-bit partial remainder is the old remainder with
    // the next dividend bit shifted in.
    assign div_shift = {work_hi, work_lo[XLEN-1]};
    assign div_ge    = (div_shift >= {1'b0, opnd});

    // Sign correction applied on the FIX cycle.
    assign fix_prod = neg_q ? -{work_hi, work_lo} : {work_hi, work_lo};

    always_comb begin
        fix_hi = neg_if(work_hi, neg_r);
        fix_lo = neg_if(work_lo, neg_q);
        if (mode_mul) begin
            fix_hi = fix_prod[2*XLEN-1:XLEN];
            fix_lo = fix_prod[XLEN-1:0];
        end
    end

    // -----------------------------------------------------------------------
    // FSM
    // -----------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (!RST) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE: begin
`ifndef FAST_MULT_EN
                if (start_mul) begin
                    state_nx = S_MUL;
                end
`endif
                if (start_div) begin
                    state_nx = b_zero ? S_FIX : S_DIV;
                end
            end
            S_MUL, S_DIV: begin
                if (cnt == CNT_W'(XLEN - 1)) begin
                    state_nx = S_FIX;
                end
            end
            S_FIX:   state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    // -----------------------------------------------------------------------
    // Architectural state: HI/LO, Done, iteration counter
    // -----------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (!RST) begin
            Hi   <= '0;
            Lo   <= '0;
            Done <= 1'b0;
            cnt  <= '0;
        end else begin
            Done <= 1'b0;
            case (state)
                S_IDLE: begin
                    cnt <= '0;
                    if (accept && func == F_MTHI) begin
                        Hi <= A;
                    end
                    if (accept && func == F_MTLO) begin
                        Lo <= A;
                    end
`ifdef FAST_MULT_EN
                    if (start_mul) begin
                        Hi   <= fast_prod[2*XLEN-1:XLEN];
                        Lo   <= fast_prod[XLEN-1:0];
                        Done <= 1'b1;
                    end
`endif
                end
                S_MUL, S_DIV: begin
                    cnt <= cnt + 1'b1;
                end
                S_FIX: begin
                    Hi   <= fix_hi;
                    Lo   <= fix_lo;
                    Done <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Working datapath (no reset: contents only matter once loaded at accept)
    // -----------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        case (state)
            S_IDLE: begin
                if (start_mul) begin
                    work_hi  <= '0;
                    work_lo  <= abs_b;
                    opnd     <= abs_a;
                    neg_q    <= sign_diff;
                    neg_r    <= 1'b0;
                    mode_mul <= 1'b1;
                end
                if (start_div) begin
                    mode_mul <= 1'b0;
                    opnd     <= abs_b;
                    if (b_zero) begin
                        work_hi <= A;
                        work_lo <= '1;
                        neg_q   <= 1'b0;
                        neg_r   <= 1'b0;
                    end else begin
                        work_hi <= '0;
                        work_lo <= abs_a;
                        neg_q   <= sign_diff;
                        neg_r   <= is_signed && A[XLEN-1];
                    end
                end
            end
            S_MUL: begin
                work_hi <= mul_sum[XLEN:1];
                work_lo <= {mul_sum[0], work_lo[XLEN-1:1]};
            end
            S_DIV: begin
                work_hi <= div_ge ? XLEN'(div_shift - {1'b0, opnd})
                                  : div_shift[XLEN-1:0];
                work_lo <= {work_lo[XLEN-2:0], div_ge};
            end
            default: ;
        endcase
    end

endmodule
